// File: rtl/car_motion_pkg.sv
// Shared game constants: screen geometry, lane Y rows, motion FSM and lane direction encodings.
package car_motion_pkg;

  localparam int SCREEN_WIDTH = 640;
  localparam int TILE_SIZE    = 32;

  localparam int LANE1_Y = 2 * TILE_SIZE;
  localparam int LANE2_Y = 3 * TILE_SIZE;
  localparam int LANE3_Y = 4 * TILE_SIZE;
  localparam int LANE4_Y = 5 * TILE_SIZE;
  localparam int LANE5_Y = 6 * TILE_SIZE;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } motion_state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } lane_dir_e;

endpackage

// File: rtl/car_lane.sv
// One traffic lane: frame divider plus a wrapping X position register moving in a fixed direction.
module car_lane
  import car_motion_pkg::*;
#(
  parameter int        SCREEN_WIDTH = car_motion_pkg::SCREEN_WIDTH,
  parameter int        DIV          = 1,
  parameter int        INIT_X       = 0,
  parameter lane_dir_e DIR          = DIR_RIGHT
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic [2:0] i_Step,
  output logic [9:0] o_X
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_x;
  logic [10:0]      w_x11;
  logic [10:0]      w_step11;
  logic [10:0]      w_sum;
  logic [9:0]       w_next;

  assign w_x11    = {1'b0, r_x};
  assign w_step11 = {8'd0, i_Step};
  assign w_sum    = w_x11 + w_step11;

  // Wrap is done at 11 bits so the sum never overflows before the compare.
  always_comb begin
    w_next = r_x;
    if (DIR == DIR_RIGHT) begin
      w_next = (w_sum < 11'(SCREEN_WIDTH)) ? w_sum[9:0]
                                           : 10'(w_sum - 11'(SCREEN_WIDTH));
    end else begin
      w_next = (w_x11 >= w_step11) ? 10'(w_x11 - w_step11)
                                   : 10'(w_x11 + 11'(SCREEN_WIDTH) - w_step11);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_x   <= 10'(INIT_X);
      r_div <= '0;
    end else if (i_En) begin
      if (r_div == DIV_W'(DIV - 1)) begin
        r_div <= '0;
        r_x   <= w_next;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign o_X = r_x;

endmodule

// File: rtl/car_motion.sv
// Five-lane car motion with level-dependent step; optional post-collision freeze under CAR_FREEZE_EN.
module car_motion
  import car_motion_pkg::*;
#(
  parameter int SCREEN_WIDTH  = car_motion_pkg::SCREEN_WIDTH,
  parameter int LANE1_DIV     = 1,
  parameter int LANE2_DIV     = 2,
  parameter int LANE3_DIV     = 1,
  parameter int LANE4_DIV     = 3,
  parameter int LANE5_DIV     = 2,
  parameter int CAR1_INIT_X   = 0,
  parameter int CAR2_INIT_X   = 160,
  parameter int CAR3_INIT_X   = 320,
  parameter int CAR4_INIT_X   = 480,
  parameter int CAR5_INIT_X   = 96,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic [1:0] i_Level,
  input  logic       i_Has_Collided,
  output logic [9:0] o_Car1_X,
  output logic [9:0] o_Car2_X,
  output logic [9:0] o_Car3_X,
  output logic [9:0] o_Car4_X,
  output logic [9:0] o_Car5_X,
  output logic       o_Frozen
);

  logic [2:0] w_step;
  logic       w_move;

  assign w_step = {1'b0, i_Level} + 3'd1;

`ifdef CAR_FREEZE_EN
  localparam int FCNT_W = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;

  motion_state_e     r_state;
  logic [FCNT_W-1:0] r_freeze_cnt;
  logic              r_frozen;

  // A collision in RUN beats a same-cycle tick; collisions in FREEZE are ignored.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= ST_RUN;
      r_freeze_cnt <= '0;
      r_frozen     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_Has_Collided) begin
            r_state      <= ST_FREEZE;
            r_freeze_cnt <= '0;
            r_frozen     <= 1'b1;
          end
        end
        ST_FREEZE: begin
          if (i_Frame_Tick) begin
            if (r_freeze_cnt == FCNT_W'(FREEZE_FRAMES - 1)) begin
              r_state  <= ST_RUN;
              r_frozen <= 1'b0;
            end else begin
              r_freeze_cnt <= r_freeze_cnt + FCNT_W'(1);
            end
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  assign w_move   = i_Frame_Tick && (r_state == ST_RUN) && !i_Has_Collided;
  assign o_Frozen = r_frozen;
`else
  logic w_unused_collided;

  assign w_unused_collided = i_Has_Collided;
  assign w_move            = i_Frame_Tick;
  assign o_Frozen          = 1'b0;
`endif

  car_lane #(.SCREEN_WIDTH(SCREEN_WIDTH), .DIV(LANE1_DIV), .INIT_X(CAR1_INIT_X), .DIR(DIR_RIGHT))
    u_lane1 (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(w_move), .i_Step(w_step), .o_X(o_Car1_X));

  car_lane #(.SCREEN_WIDTH(SCREEN_WIDTH), .DIV(LANE2_DIV), .INIT_X(CAR2_INIT_X), .DIR(DIR_LEFT))
    u_lane2 (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(w_move), .i_Step(w_step), .o_X(o_Car2_X));

  car_lane #(.SCREEN_WIDTH(SCREEN_WIDTH), .DIV(LANE3_DIV), .INIT_X(CAR3_INIT_X), .DIR(DIR_RIGHT))
    u_lane3 (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(w_move), .i_Step(w_step), .o_X(o_Car3_X));

  car_lane #(.SCREEN_WIDTH(SCREEN_WIDTH), .DIV(LANE4_DIV), .INIT_X(CAR4_INIT_X), .DIR(DIR_LEFT))
    u_lane4 (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(w_move), .i_Step(w_step), .o_X(o_Car4_X));

  car_lane #(.SCREEN_WIDTH(SCREEN_WIDTH), .DIV(LANE5_DIV), .INIT_X(CAR5_INIT_X), .DIR(DIR_RIGHT))
    u_lane5 (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_En(w_move), .i_Step(w_step), .o_X(o_Car5_X));

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion: directed literal scenarios plus randomized traffic against a modulo-arithmetic model.
module tb_car_motion;

  localparam int W  = 640;
  localparam int FF = 60;
`ifdef CAR_FREEZE_EN
  localparam bit FREEZE_ON = 1'b1;
`else
  localparam bit FREEZE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] level = 2'd0;
  logic       coll = 1'b0;
  logic [9:0] car_x [5];
  logic       frozen;

  logic       wtick = 1'b0;
  logic       wcoll = 1'b0;
  logic [9:0] w1, w2, w3, w4, w5;
  logic       wfrz;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  car_motion u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Frame_Tick(tick), .i_Level(level),
    .i_Has_Collided(coll),
    .o_Car1_X(car_x[0]), .o_Car2_X(car_x[1]), .o_Car3_X(car_x[2]),
    .o_Car4_X(car_x[3]), .o_Car5_X(car_x[4]), .o_Frozen(frozen)
  );

  // Second instance placed near the wrap points so both wrap directions can be pinned literally.
  car_motion #(.CAR1_INIT_X(634), .CAR2_INIT_X(1)) u_wrap (
    .i_Clk(clk), .i_Rst(rst), .i_Frame_Tick(wtick), .i_Level(2'd3),
    .i_Has_Collided(wcoll),
    .o_Car1_X(w1), .o_Car2_X(w2), .o_Car3_X(w3), .o_Car4_X(w4),
    .o_Car5_X(w5), .o_Frozen(wfrz)
  );

  // Reference model: positions advance modulo the screen width every DIV-th qualifying tick.
  int init_x [5] = '{0, 160, 320, 480, 96};
  int div    [5] = '{1, 2, 1, 3, 2};
  bit right  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int m_pos  [5];
  int m_ticks[5];
  bit m_frozen;
  int m_fticks;

  always @(posedge clk) begin
    int step;
    step = int'(level) + 1;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_pos[i]   = init_x[i];
        m_ticks[i] = 0;
      end
      m_frozen = 1'b0;
      m_fticks = 0;
    end else if (FREEZE_ON && !m_frozen && coll) begin
      m_frozen = 1'b1;
      m_fticks = 0;
    end else if (m_frozen) begin
      if (tick) begin
        m_fticks++;
        if (m_fticks == FF) m_frozen = 1'b0;
      end
    end else if (tick) begin
      for (int i = 0; i < 5; i++) begin
        m_ticks[i]++;
        if (m_ticks[i] == div[i]) begin
          m_ticks[i] = 0;
          m_pos[i] = right[i] ? (m_pos[i] + step) % W : (m_pos[i] - step + W) % W;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 5; i++) check($sformatf("model car%0d", i + 1), int'(car_x[i]), m_pos[i]);
      check("model frozen", int'(frozen), int'(m_frozen));
    end
  end

  task automatic cyc(input bit t, input bit c, input bit r);
    tick = t;
    coll = c;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk_en = 1'b1;
    cyc(0, 0, 0);
    check("reset car1", int'(car_x[0]), 0);
    check("reset car2", int'(car_x[1]), 160);
    check("reset car3", int'(car_x[2]), 320);
    check("reset car4", int'(car_x[3]), 480);
    check("reset car5", int'(car_x[4]), 96);
    check("reset frozen", int'(frozen), 0);

    // Six level-0 ticks with idle cycles in between: outputs must hold between ticks.
    level = 2'd0;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    check("div car1", int'(car_x[0]), 6);
    check("div car2", int'(car_x[1]), 157);
    check("div car3", int'(car_x[2]), 326);
    check("div car4", int'(car_x[3]), 478);
    check("div car5", int'(car_x[4]), 99);

    // Wrap instance: step 4, car1 634->638->2, car2 holds on tick 1 then 1->637.
    wtick = 1'b1; @(posedge clk); #1; wtick = 1'b0;
    check("wrap car1 pre", int'(w1), 638);
    check("wrap car2 pre", int'(w2), 1);
    wtick = 1'b1; @(posedge clk); #1; wtick = 1'b0;
    check("wrap car1 right", int'(w1), 2);
    check("wrap car2 left", int'(w2), 637);

`ifdef CAR_FREEZE_EN
    cyc(1, 1, 0);
    check("coll no move", int'(car_x[0]), 6);
    check("coll frozen", int'(frozen), 1);
    for (int k = 0; k < 59; k++) cyc(1, 0, 0);
    check("frz 59 frozen", int'(frozen), 1);
    check("frz 59 car1", int'(car_x[0]), 6);
    cyc(1, 0, 0);
    check("frz 60 frozen", int'(frozen), 0);
    check("frz 60 car1", int'(car_x[0]), 6);
    cyc(1, 0, 0);
    check("frz 61 car1", int'(car_x[0]), 7);

    cyc(0, 1, 0);
    check("mid frz", int'(frozen), 1);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    check("rst frz car1", int'(car_x[0]), 0);
    check("rst frz car2", int'(car_x[1]), 160);
    check("rst frz frozen", int'(frozen), 0);
    cyc(1, 0, 0);
    check("post rst car1", int'(car_x[0]), 1);
`else
    cyc(1, 1, 0);
    check("nomacro car1", int'(car_x[0]), 7);
    check("nomacro frozen", int'(frozen), 0);
`endif

    // Randomized traffic: sparse ticks, rare collisions and resets, random level.
    for (int k = 0; k < 3000; k++) begin
      level = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
    end

    cyc(0, 0, 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
